// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB request arbiter.
//   state_e : transfer sequencer states (IDLE, SETUP, ACCESS, RESP)
//   grant_e : which requester owns the current transfer
//   PPROT_DEFAULT : pprot value driven out of reset
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_e;

    typedef enum logic {
        GNT_WR,
        GNT_RD
    } grant_e;

    localparam logic [2:0] PPROT_DEFAULT = 3'b000;

endpackage

// File: rtl/apb_rr_arb2.sv
// Two-input round-robin arbiter.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset (last grant returns to read side)
//   req[1:0]   : requests, bit 0 = write side, bit 1 = read side
//   update     : record the current grant as the last grant
//   gnt[1:0]   : one-hot grant, combinational from req and last grant
module apb_rr_arb2
    import apb_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    grant_e last_grant;

    // A single requester always wins; on a tie the side that did not go last wins.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last_grant == GNT_RD) ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GNT_RD;
        end else if (update) begin
            last_grant <= gnt[1] ? GNT_RD : GNT_WR;
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB master port between a write requester and a read requester.
// One transfer in flight at a time; ties are resolved round-robin (write first
// after reset). The response is held until the granted side accepts it.
//
// Ports:
//   pclk, preset                   : clock, synchronous active-high reset
//   wr_req_* / wr_addr..wr_prot    : write request handshake and payload
//   wr_rsp_valid/ready/err         : write response
//   rd_req_* / rd_addr, rd_prot    : read request handshake and payload
//   rd_rsp_valid/ready/data/err    : read response (data holds its last value)
//   paddr..pstrb, pselx, penable   : APB request
//   pready, prdata, pslverr        : APB completer response
//
// Build option: define APB_TIMEOUT_EN to end an ACCESS phase with an error
// response after TIMEOUT_CYCLES wait cycles without pready.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                    pclk,
    input  logic                    preset,

    input  logic                    wr_req_valid,
    output logic                    wr_req_ready,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic [2:0]              wr_prot,
    output logic                    wr_rsp_valid,
    input  logic                    wr_rsp_ready,
    output logic                    wr_rsp_err,

    input  logic                    rd_req_valid,
    output logic                    rd_req_ready,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic [2:0]              rd_prot,
    output logic                    rd_rsp_valid,
    input  logic                    rd_rsp_ready,
    output logic [DATA_WIDTH-1:0]   rd_rsp_data,
    output logic                    rd_rsp_err,

    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [2:0]              pprot,
    output logic                    pselx,
    output logic                    penable,
    output logic                    pwrite,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic                    pready,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pslverr
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 1");
    end

    state_e                  state, state_next;
    grant_e                  gnt_q;
    logic [1:0]              arb_req, arb_gnt;
    logic                    accept, wr_sel, xfer_done, timeout_hit, rsp_taken;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic [2:0]              pprot_q;
    logic                    pwrite_q;
    logic [DATA_WIDTH-1:0]   pwdata_q;
    logic [DATA_WIDTH/8-1:0] pstrb_q;
    logic                    rsp_err_q;
    logic [DATA_WIDTH-1:0]   rd_data_q;

    // Requests reach the arbiter only in IDLE, so ready is low everywhere else.
    assign arb_req = (state == IDLE) ? {rd_req_valid, wr_req_valid} : 2'b00;

    apb_rr_arb2 u_arb (
        .clk    (pclk),
        .rst    (preset),
        .req    (arb_req),
        .update (accept),
        .gnt    (arb_gnt)
    );

    assign wr_req_ready = arb_gnt[0];
    assign rd_req_ready = arb_gnt[1];
    assign wr_sel       = arb_gnt[0];
    assign accept       = |arb_gnt;
    assign xfer_done    = (state == ACCESS) && pready;
    assign rsp_taken    = (state == RESP) &&
                          ((gnt_q == GNT_WR) ? wr_rsp_ready : rd_rsp_ready);

`ifdef APB_TIMEOUT_EN
    localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Counts ACCESS cycles without pready; cleared in SETUP so it starts at 0.
    always_ff @(posedge pclk) begin
        if (preset || state == SETUP) begin
            tmo_cnt <= '0;
        end else if (state == ACCESS && !pready) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state == ACCESS) && !pready && (tmo_cnt == TMO_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next   = state;
        pselx        = 1'b0;
        penable      = 1'b0;
        wr_rsp_valid = 1'b0;
        rd_rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_next = SETUP;
            end
            SETUP: begin
                pselx      = 1'b1;
                state_next = ACCESS;
            end
            ACCESS: begin
                pselx   = 1'b1;
                penable = 1'b1;
                if (xfer_done || timeout_hit) state_next = RESP;
            end
            RESP: begin
                wr_rsp_valid = (gnt_q == GNT_WR);
                rd_rsp_valid = (gnt_q == GNT_RD);
                if (rsp_taken) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state     <= IDLE;
            gnt_q     <= GNT_WR;
            paddr_q   <= '0;
            pprot_q   <= PPROT_DEFAULT;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            rsp_err_q <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                gnt_q    <= wr_sel ? GNT_WR : GNT_RD;
                paddr_q  <= wr_sel ? wr_addr : rd_addr;
                pprot_q  <= wr_sel ? wr_prot : rd_prot;
                pwrite_q <= wr_sel;
                pwdata_q <= wr_sel ? wr_data : '0;
                pstrb_q  <= wr_sel ? wr_strb : '0;
            end
            // pready/pslverr are only looked at in ACCESS; pready beats a timeout.
            if (xfer_done) begin
                rsp_err_q <= pslverr;
                if (gnt_q == GNT_RD) rd_data_q <= prdata;
            end else if (timeout_hit) begin
                rsp_err_q <= 1'b1;
                if (gnt_q == GNT_RD) rd_data_q <= '0;
            end
        end
    end

    assign paddr       = paddr_q;
    assign pprot       = pprot_q;
    assign pwrite      = pwrite_q;
    assign pwdata      = pwdata_q;
    assign pstrb       = pstrb_q;
    assign wr_rsp_err  = wr_rsp_valid & rsp_err_q;
    assign rd_rsp_err  = rd_rsp_valid & rsp_err_q;
    assign rd_rsp_data = rd_data_q;

endmodule
